// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared types and constants for the sequential Booth multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int MULT_WIDTH = 32;

    // Controller states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Radix-2 Booth pair {q[0], q_m1} encodings. 2'b11 is also a no-op.
    localparam logic [1:0] c_BOOTH_NOP = 2'b00;
    localparam logic [1:0] c_BOOTH_ADD = 2'b01;
    localparam logic [1:0] c_BOOTH_SUB = 2'b10;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_if
//  Purpose  : start/finished handshake plus operand and HI/LO result bus.
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             finished;

    // Control unit side: issues operands, reads the product.
    modport master (
        output start, A, B,
        input  HI, LO, finished
    );

    // Multiplier side.
    modport slave (
        input  start, A, B,
        output HI, LO, finished
    );
endinterface : mult_if
`default_nettype wire

// File: rtl/mult_booth_step.sv
`default_nettype none
// ============================================================================
//  Module   : mult_booth_step
//  Purpose  : One combinational radix-2 Booth iteration: conditional add/sub
//             of the multiplicand followed by an arithmetic right shift of
//             {acc, q, q_m1}.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  wire logic [WIDTH:0]   i_acc,
    input  wire logic [WIDTH-1:0] i_q,
    input  wire logic             i_q_m1,
    input  wire logic [WIDTH-1:0] i_m,
    output logic      [WIDTH:0]   o_acc,
    output logic      [WIDTH-1:0] o_q,
    output logic                  o_q_m1
);
    // Multiplicand sign-extended to the accumulator width so that
    // subtracting the most negative value cannot overflow.
    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_sum;

    assign w_m_ext = {i_m[WIDTH-1], i_m};

    // Add, subtract or pass through according to the Booth pair.
    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_q_m1})
            c_BOOTH_NOP: w_sum = i_acc;
            c_BOOTH_ADD: w_sum = i_acc + w_m_ext;
            c_BOOTH_SUB: w_sum = i_acc - w_m_ext;
            default:     w_sum = i_acc;
        endcase
    end

    // Arithmetic shift right of the concatenation, replicating the acc MSB.
    assign o_acc  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q    = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q_m1 = i_q[0];

endmodule : mult_booth_step
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// ============================================================================
//  Module   : mult
//  Purpose  : Sequential signed WIDTH x WIDTH Booth multiplier, one
//             iteration per clock, HI/LO result pair for MIPS MULT.
//  Revision : 1.0 - initial release
// ============================================================================
module mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  wire logic clock,
    input  wire logic reset,
    mult_if.slave     bus
);
    localparam int              CW           = $clog2(WIDTH);
    localparam logic [CW-1:0]   c_COUNT_LAST = CW'(WIDTH - 1);

    state_t           r_state, w_state_next;
    logic [WIDTH:0]   r_acc,   w_acc_next;
    logic [WIDTH-1:0] r_q,     w_q_next;
    logic             r_q_m1,  w_q_m1_next;
    logic [WIDTH-1:0] r_m,     w_m_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic [WIDTH-1:0] r_hi,    w_hi_next;
    logic [WIDTH-1:0] r_lo,    w_lo_next;

    logic [WIDTH:0]   w_step_acc;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_q_m1;

    mult_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .i_m    (r_m),
        .o_acc  (w_step_acc),
        .o_q    (w_step_q),
        .o_q_m1 (w_step_q_m1)
    );

    // State and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_m     <= '0;
            r_count <= c_COUNT_LAST;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_q     <= w_q_next;
            r_q_m1  <= w_q_m1_next;
            r_m     <= w_m_next;
            r_count <= w_count_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
        end
    end

    // Next-state logic: start always wins, even on the final iteration.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_q_next     = r_q;
        w_q_m1_next  = r_q_m1;
        w_m_next     = r_m;
        w_count_next = r_count;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;

        if (bus.start) begin
            w_m_next     = bus.A;
            w_acc_next   = '0;
            w_q_next     = bus.B;
            w_q_m1_next  = 1'b0;
            w_count_next = c_COUNT_LAST;
            w_state_next = BUSY;
        end else if (r_state == BUSY) begin
            w_acc_next  = w_step_acc;
            w_q_next    = w_step_q;
            w_q_m1_next = w_step_q_m1;
            if (r_count == '0) begin
                w_hi_next    = w_step_acc[WIDTH-1:0];
                w_lo_next    = w_step_q;
                w_state_next = IDLE;
            end else begin
                w_count_next = r_count - CW'(1);
            end
        end
    end

    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
    assign bus.finished = (r_state == IDLE);

endmodule : mult
`default_nettype wire

// File: tb/tb_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult
//  Purpose  : Self-checking bench for the sequential Booth multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        string          name;
    } vec_t;

    logic clock;
    logic reset;

    mult_if #(.WIDTH(W)) bus ();

    mult #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int             n_pass  = 0;
    int             n_total = 0;
    logic [W-1:0]   last_hi = '0;
    logic [W-1:0]   last_lo = '0;
    logic [2*W-1:0] sb[$];
    vec_t           vecs[6];

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue a one-cycle start; operands are scrambled afterwards.
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clock);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Count cycles until finished, watching that HI/LO never move meanwhile.
    task automatic wait_done(output int cyc, output bit held);
        cyc  = 0;
        held = 1'b1;
        while (!bus.finished && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (!bus.finished && (bus.HI !== last_hi || bus.LO !== last_lo)) held = 1'b0;
        end
    endtask

    // Pop the scoreboard and compare against the delivered product.
    task automatic complete(input string tag);
        logic [2*W-1:0] exp;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        n_pass++;
        exp = sb.pop_front();
        check({tag, " HI"}, {32'h0, bus.HI}, {32'h0, exp[63:32]});
        check({tag, " LO"}, {32'h0, bus.LO}, {32'h0, exp[31:0]});
        last_hi = exp[63:32];
        last_lo = exp[31:0];
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string tag);
        int cyc;
        bit held;
        pulse_start(a, b);
        sb.push_back(exp);
        wait_done(cyc, held);
        check({tag, " latency"}, 64'(cyc), 64'd32);
        check({tag, " hold"}, 64'(held), 64'd1);
        complete(tag);
    endtask

    initial begin
        int cyc;
        bit held;
        logic [W-1:0] ra, rb;

        vecs[0] = '{32'd7,        32'd3,        64'h00000000_00000015, "7x3"};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "m1xm1"};
        vecs[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_80000001, "maxxm1"};
        vecs[3] = '{32'hFFFFFFFB, 32'd6,        64'hFFFFFFFF_FFFFFFE2, "m5x6"};
        vecs[4] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000, "minxmin"};
        vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, "minxmax"};

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset HI", {32'h0, bus.HI}, 64'h0);
        check("reset LO", {32'h0, bus.LO}, 64'h0);
        check("reset finished", 64'(bus.finished), 64'd1);

        for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // Restart while busy: first product never appears.
        pulse_start(32'd7, 32'd3);
        sb.push_back(64'd21);
        repeat (10) @(negedge clock);
        check("restart busy", 64'(bus.finished), 64'd0);
        pulse_start(32'd2, 32'd5);
        sb.delete();
        sb.push_back(64'd10);
        wait_done(cyc, held);
        check("restart latency", 64'(cyc), 64'd32);
        check("restart hold", 64'(held), 64'd1);
        complete("restart");

        // Start coincides with the final iteration edge.
        pulse_start(32'd123, 32'hFFFFFFFC);
        sb.push_back(ref_mul(32'd123, 32'hFFFFFFFC));
        repeat (31) @(negedge clock);
        check("lastedge pre finished", 64'(bus.finished), 64'd0);
        bus.start = 1'b1;
        bus.A     = 32'hFFFF0001;
        bus.B     = 32'h00012345;
        @(negedge clock);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        check("lastedge finished", 64'(bus.finished), 64'd0);
        check("lastedge HI", {32'h0, bus.HI}, {32'h0, last_hi});
        check("lastedge LO", {32'h0, bus.LO}, {32'h0, last_lo});
        sb.delete();
        sb.push_back(ref_mul(32'hFFFF0001, 32'h00012345));
        wait_done(cyc, held);
        check("lastedge latency", 64'(cyc), 64'd32);
        check("lastedge hold", 64'(held), 64'd1);
        complete("lastedge");

        // Asynchronous reset mid-multiply.
        pulse_start(32'd9, 32'd9);
        sb.push_back(64'd81);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset HI", {32'h0, bus.HI}, 64'h0);
        check("midreset LO", {32'h0, bus.LO}, 64'h0);
        check("midreset finished", 64'(bus.finished), 64'd1);
        sb.delete();
        last_hi = '0;
        last_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        held = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (!bus.finished || bus.HI !== 32'h0 || bus.LO !== 32'h0) held = 1'b0;
        end
        check("midreset stays idle", 64'(held), 64'd1);

        // Random signed operands against the 64-bit reference model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mult
`default_nettype wire
